// File: rtl/writeback_arbiter.sv
// Register-file writeback arbiter: ALU results always win, and long-latency results
// either bypass straight to the write port or wait in a small FIFO.
module writeback_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        mem_valid,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_data,
    output logic        mem_ready,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        stall_alu,
    output logic [31:0] pend_mask
);
    localparam int         PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int         CNT_W = $clog2(DEPTH + 1);
    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    logic [4:0]       fifo_rd   [DEPTH];
    logic [31:0]      fifo_data [DEPTH];
    logic [DEPTH-1:0] slot_valid;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [2:0]       starve_cnt;
    logic [2:0]       starve_nxt;
    logic             fifo_empty;
    logic             pop;
    logic             bypass;
    logic             push;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign fifo_empty = (count == '0);
    assign mem_ready  = (count < CNT_W'(DEPTH));
    assign pop        = !alu_valid && !fifo_empty;
    assign bypass     = !alu_valid && fifo_empty && mem_valid;
    assign push       = mem_valid && mem_ready && !bypass;

    // The starvation counter only runs while the ALU is blocking a waiting entry.
    always_comb begin
        starve_nxt = starve_cnt;
        if (pop || fifo_empty)
            starve_nxt = '0;
        else if (alu_valid && starve_cnt != 3'd7)
            starve_nxt = starve_cnt + 3'd1;
    end

    // Slot-valid bits make the pending mask a simple OR over occupied slots.
    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++)
            if (slot_valid[i])
                pend_mask[fifo_rd[i]] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_ptr]   <= mem_rd;
            fifo_data[wr_ptr] <= mem_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            slot_valid <= '0;
            starve_cnt <= '0;
            stall_alu  <= 1'b0;
        end else begin
            if (pop) begin
                rd_ptr             <= ptr_inc(rd_ptr);
                slot_valid[rd_ptr] <= 1'b0;
            end
            if (push) begin
                wr_ptr             <= ptr_inc(wr_ptr);
                slot_valid[wr_ptr] <= 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            starve_cnt <= starve_nxt;
            stall_alu  <= (starve_nxt >= LIMIT);
        end
    end

    // Writes to x0 still consume their turn but never assert the write enable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_we   <= 1'b0;
            wb_rd   <= '0;
            wb_data <= '0;
        end else if (alu_valid) begin
            wb_we   <= (alu_rd != 5'd0);
            wb_rd   <= alu_rd;
            wb_data <= alu_data;
        end else if (pop) begin
            wb_we   <= (fifo_rd[rd_ptr] != 5'd0);
            wb_rd   <= fifo_rd[rd_ptr];
            wb_data <= fifo_data[rd_ptr];
        end else if (bypass) begin
            wb_we   <= (mem_rd != 5'd0);
            wb_rd   <= mem_rd;
            wb_data <= mem_data;
        end else begin
            wb_we   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a queue-based model.
module tb_writeback_arbiter;
    localparam int DEPTH        = 2;
    localparam int STARVE_LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        stall_alu;
    logic [31:0] pend_mask;

    int vectors     = 0;
    int miscompares = 0;
    bit check_en    = 1'b0;

    writeback_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
        .mem_ready(mem_ready),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .stall_alu(stall_alu), .pend_mask(pend_mask)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } entry_t;

    entry_t      q[$];
    logic        m_we    = 1'b0;
    logic [4:0]  m_rd    = '0;
    logic [31:0] m_data  = '0;
    int          m_run   = 0;
    logic        m_stall = 1'b0;

    function automatic logic [31:0] modelPend();
        logic [31:0] m = '0;
        foreach (q[i]) m[q[i].rd] = 1'b1;
        return m;
    endfunction

    // Model: one arbitration decision per rising edge, from the rules in plain terms.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            q.delete();
            m_we = 1'b0; m_rd = '0; m_data = '0; m_run = 0; m_stall = 1'b0;
        end else if (clk) begin
            bit     accept;
            bit     popped;
            bit     had_entries;
            entry_t e;
            accept      = mem_valid && (q.size() < DEPTH);
            popped      = 1'b0;
            had_entries = (q.size() > 0);
            if (alu_valid) begin
                m_we = (alu_rd != 0); m_rd = alu_rd; m_data = alu_data;
            end else if (had_entries) begin
                e = q.pop_front();
                m_we = (e.rd != 0); m_rd = e.rd; m_data = e.data;
                popped = 1'b1;
            end else if (mem_valid) begin
                m_we = (mem_rd != 0); m_rd = mem_rd; m_data = mem_data;
                accept = 1'b0;
            end else begin
                m_we = 1'b0;
            end
            if (popped || !had_entries) m_run = 0;
            else if (alu_valid && m_run < 7) m_run++;
            m_stall = (m_run >= STARVE_LIMIT);
            if (accept) begin
                e.rd = mem_rd; e.data = mem_data;
                q.push_back(e);
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("model wb_we",     32'(wb_we),     32'(m_we));
            checkOutput("model wb_rd",     32'(wb_rd),     32'(m_rd));
            checkOutput("model wb_data",   wb_data,        m_data);
            checkOutput("model stall_alu", 32'(stall_alu), 32'(m_stall));
            checkOutput("model mem_ready", 32'(mem_ready), 32'(q.size() < DEPTH));
            checkOutput("model pend_mask", pend_mask,      modelPend());
        end
    end

    task automatic applyStimulus(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                                 input logic mv, input logic [4:0] mrd, input logic [31:0] md);
        alu_valid = av; alu_rd = ard; alu_data = ad;
        mem_valid = mv; mem_rd = mrd; mem_data = md;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int alu_pct;
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0);
        #2 reset = 1'b0;
        #1 check_en = 1'b1;
        checkOutput("reset wb_we", 32'(wb_we), 32'd0);
        checkOutput("reset mem_ready", 32'(mem_ready), 32'd1);
        checkOutput("reset pend_mask", pend_mask, 32'd0);
        stepCycle();
        stepCycle();
        reset = 1'b1;

        // Bypass of a lone mem result
        applyStimulus(0, 0, 0, 1, 5, 32'hDEADBEEF);
        stepCycle();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("bypass wb_we", 32'(wb_we), 32'd1);
        checkOutput("bypass wb_rd", 32'(wb_rd), 32'd5);
        checkOutput("bypass wb_data", wb_data, 32'hDEADBEEF);
        checkOutput("bypass pend_mask", pend_mask, 32'd0);

        // ALU and mem collide
        applyStimulus(1, 3, 32'h11, 1, 7, 32'h22);
        stepCycle();
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("collide c1 wb_rd", 32'(wb_rd), 32'd3);
        checkOutput("collide c1 wb_data", wb_data, 32'h11);
        checkOutput("collide c1 pend_mask", pend_mask, 32'h80);
        stepCycle();
        checkOutput("collide c2 wb_we", 32'(wb_we), 32'd1);
        checkOutput("collide c2 wb_rd", 32'(wb_rd), 32'd7);
        checkOutput("collide c2 wb_data", wb_data, 32'h22);
        checkOutput("collide c2 pend_mask", pend_mask, 32'd0);
        stepCycle();
        checkOutput("idle wb_we", 32'(wb_we), 32'd0);
        checkOutput("idle wb_rd hold", 32'(wb_rd), 32'd7);

        // Fill the FIFO behind a busy ALU, then drain in order
        applyStimulus(1, 1, 32'h1, 1, 8, 32'h88);
        stepCycle();
        applyStimulus(1, 1, 32'h1, 1, 9, 32'h99);
        stepCycle();
        checkOutput("full mem_ready", 32'(mem_ready), 32'd0);
        checkOutput("full pend_mask", pend_mask, 32'h300);
        applyStimulus(0, 0, 0, 0, 0, 0);
        stepCycle();
        checkOutput("drain1 wb_rd", 32'(wb_rd), 32'd8);
        checkOutput("drain1 wb_data", wb_data, 32'h88);
        stepCycle();
        checkOutput("drain2 wb_rd", 32'(wb_rd), 32'd9);
        checkOutput("drain2 wb_data", wb_data, 32'h99);

        // Starvation raises stall_alu, the first idle ALU cycle drops it
        applyStimulus(1, 2, 32'h2, 1, 10, 32'hA);
        stepCycle();
        applyStimulus(1, 2, 32'h2, 0, 0, 0);
        stepCycle(); stepCycle(); stepCycle();
        checkOutput("starve c4 stall", 32'(stall_alu), 32'd0);
        stepCycle();
        checkOutput("starve c5 stall", 32'(stall_alu), 32'd1);
        applyStimulus(0, 0, 0, 0, 0, 0);
        stepCycle();
        checkOutput("starve pop wb_rd", 32'(wb_rd), 32'd10);
        checkOutput("starve pop stall", 32'(stall_alu), 32'd0);

        // x0 entries occupy a slot but never write
        applyStimulus(1, 4, 32'h4, 1, 0, 32'hFFFFFFFF);
        stepCycle();
        applyStimulus(1, 4, 32'h4, 1, 12, 32'hC);
        stepCycle();
        checkOutput("x0 full mem_ready", 32'(mem_ready), 32'd0);
        checkOutput("x0 pend_mask", pend_mask, 32'h1001);
        applyStimulus(0, 0, 0, 0, 0, 0);
        stepCycle();
        checkOutput("x0 wb_we", 32'(wb_we), 32'd0);
        checkOutput("x0 mem_ready", 32'(mem_ready), 32'd1);
        stepCycle();
        checkOutput("x0 next wb_rd", 32'(wb_rd), 32'd12);

        // Reset mid-flight with a full FIFO
        applyStimulus(1, 6, 32'h6, 1, 20, 32'h20);
        stepCycle();
        applyStimulus(1, 6, 32'h6, 1, 21, 32'h21);
        stepCycle();
        applyStimulus(0, 0, 0, 0, 0, 0);
        #2 reset = 1'b0;
        #1;
        checkOutput("midreset wb_we", 32'(wb_we), 32'd0);
        checkOutput("midreset wb_rd", 32'(wb_rd), 32'd0);
        checkOutput("midreset wb_data", wb_data, 32'd0);
        checkOutput("midreset pend_mask", pend_mask, 32'd0);
        checkOutput("midreset mem_ready", 32'(mem_ready), 32'd1);
        stepCycle();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            stepCycle();
            checkOutput("post-reset wb_we", 32'(wb_we), 32'd0);
        end

        // Randomized traffic at several ALU load levels
        for (int phase = 0; phase < 6; phase++) begin
            alu_pct = (phase % 3 == 0) ? 20 : (phase % 3 == 1) ? 60 : 92;
            for (int c = 0; c < 400; c++) begin
                applyStimulus(($urandom_range(0, 99) < alu_pct),
                              5'($urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(0, 31)),
                              $urandom,
                              ($urandom_range(0, 99) < 55),
                              5'($urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(0, 31)),
                              $urandom);
                stepCycle();
            end
        end
        applyStimulus(0, 0, 0, 0, 0, 0);
        stepCycle();
        stepCycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 Parameter DEPTH, default 2: number of entries in the long-latency result FIFO.
REQ-002 Parameter STARVE_LIMIT, default 4: consecutive blocked cycles before ALU stall is requested.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 alu_valid  input  1  ALU result present this cycle; no back-pressure, always accepted.
REQ-006 alu_rd  input  5  ALU destination register index.
REQ-007 alu_data  input  32  ALU result value.
REQ-008 mem_valid  input  1  load/multiply result offered.
REQ-009 mem_rd  input  5  load/multiply destination register index.
REQ-010 mem_data  input  32  load/multiply result value.
REQ-011 mem_ready  output  1  mem result accepted this cycle when mem_valid and mem_ready are both high.
REQ-012 wb_we  output  1  register-file write enable; drives write_register_d.
REQ-013 wb_rd  output  5  register-file write index; drives register_d.
REQ-014 wb_data  output  32  register-file write data; drives data_register_d_in.
REQ-015 stall_alu  output  1  request for upstream to withhold alu_valid.
REQ-016 pend_mask  output  32  bit i set while any FIFO entry targets register i.

Function
REQ-017 wb_we, wb_rd and wb_data shall be registered, with 1-cycle latency from the winning input to the output.
REQ-018 Selection priority each cycle shall be: alu_valid, then FIFO head, then mem bypass.
REQ-019 Mem bypass shall occur only when alu_valid=0, the FIFO is empty and mem_valid=1; the accepted result then goes directly to the output register and is not pushed.
REQ-020 Otherwise an accepted mem result shall be pushed to the FIFO tail.
REQ-021 mem_ready shall equal (FIFO count < DEPTH), computed from the current count only.
REQ-022 A push and a pop in the same cycle shall leave the count unchanged and preserve FIFO order.
REQ-023 Any selected result with rd==0 shall produce wb_we=0 next cycle, while still consuming its slot or pop.
REQ-024 When no source wins, wb_we shall be 0 next cycle, and wb_rd/wb_data shall hold their previous values.
REQ-025 starve_cnt (3 bits, saturating) shall increment on each cycle with FIFO non-empty and alu_valid=1.
REQ-026 starve_cnt shall clear on any FIFO pop, or when the FIFO is empty.
REQ-027 stall_alu shall be registered: high in the cycle after starve_cnt reaches STARVE_LIMIT, and low in the cycle after the next pop.
REQ-028 An alu_valid arriving while stall_alu=1 shall still win; starve_cnt shall stay saturated.
REQ-029 pend_mask shall be combinational from the valid FIFO entries only; the bypass path and the output register are excluded.
REQ-030 Two FIFO entries with the same rd shall both set the same pend_mask bit; the bit clears only when neither remains.
REQ-031 FIFO pointers shall wrap modulo DEPTH.

Reset
REQ-032 reset low shall immediately set FIFO count, pointers and starve_cnt to 0.
REQ-033 reset low shall immediately force wb_we=0, wb_rd=0, wb_data=0, stall_alu=0 and pend_mask=0; mem_ready shall read 1.
REQ-034 Reset asserted mid-operation shall discard all buffered results with no write issued.
REQ-035 The first write after reset release shall come from inputs sampled at the first rising edge with reset high.

Verification
REQ-036 Bypass: alu_valid=0, mem_valid=1, rd=5, data=0xDEADBEEF, FIFO empty -> next cycle wb_we=1, wb_rd=5, wb_data=0xDEADBEEF; pend_mask stays 0.
REQ-037 Collision: alu (rd=3, 0x11) and mem (rd=7, 0x22) in the same cycle -> cycle+1 writes r3=0x11; cycle+2 writes r7=0x22; pend_mask bit7=1 during cycle+1 only.
REQ-038 Full: alu_valid held 1, mem offers rd=8, then rd=9 -> mem_ready=0 after 2 pushes, pend_mask=0x300; drop alu_valid -> r8 then r9 written in order.
REQ-039 Starvation: FIFO holds one entry, alu_valid=1 for 4 cycles -> stall_alu=1 on the 5th cycle; first alu-idle cycle pops the head; stall_alu=0 the following cycle.
REQ-040 x0: mem result rd=0, data=0xFFFFFFFF -> wb_we stays 0, the FIFO slot is freed, and mem_ready returns to 1.
REQ-041 Reset mid-flight: FIFO full, reset pulsed low between edges -> outputs zero immediately; after release, no write of the discarded entries ever appears.
